// File: rtl/centroid_pkg.sv
// Shared widths, FSM states and rounding modes for the multi-channel centroid block.
package centroid_pkg;

  function automatic int unsigned cnt_width(input int unsigned h, input int unsigned v);
    return h + v;
  endfunction

  function automatic int unsigned sx_width(input int unsigned h, input int unsigned v);
    return cnt_width(h, v) + h;
  endfunction

  function automatic int unsigned sy_width(input int unsigned h, input int unsigned v);
    return cnt_width(h, v) + v;
  endfunction

  function automatic int unsigned div_width(input int unsigned h, input int unsigned v);
    return (sx_width(h, v) > sy_width(h, v)) ? sx_width(h, v) : sy_width(h, v);
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDiv,
    StEmit
  } state_e;

  localparam int unsigned RoundTrunc  = 0;
  localparam int unsigned RoundHalfUp = 1;

endpackage

// File: rtl/centroid_divider.sv
// Restoring serial divider: one quotient bit per cycle, DW cycles after start.
module centroid_divider #(
  parameter int unsigned DW = 32,
  parameter int unsigned VW = 21
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [VW-1:0] divisor_i,
  output logic [DW-1:0] quotient_o,
  output logic          done_o
);

  localparam int unsigned CW = $clog2(DW + 1);

  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d, dsr_q, dsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic [VW:0]   rem_sh, diff;

  // Next-state: load on start, otherwise shift in one dividend bit and trial-subtract.
  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    rem_sh = {rem_q, quo_q[DW-1]};
    diff   = rem_sh - {1'b0, dsr_q};
    if (start_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dsr_d = divisor_i;
      cnt_d = CW'(DW);
      run_d = 1'b1;
    end else if (run_q) begin
      // Remainder stays below the divisor, so VW bits always hold it.
      if (rem_sh >= {1'b0, dsr_q}) begin
        rem_d = diff[VW-1:0];
        quo_d = {quo_q[DW-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[VW-1:0];
        quo_d = {quo_q[DW-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) run_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  // Done marks the final iteration; the quotient is complete the following cycle.
  assign done_o     = run_q && (cnt_q == CW'(1));
  assign quotient_o = quo_q;

endmodule

// File: rtl/multi_centroid.sv
// Per-channel centre-of-mass accumulator with snapshot and serial divide of each channel.
module multi_centroid
  import centroid_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned H_WIDTH   = 11,
  parameter int unsigned V_WIDTH   = 10,
  parameter int unsigned MIN_COUNT = 1,
  parameter int unsigned ROUND     = RoundTrunc,
  localparam int unsigned CNT_W    = cnt_width(H_WIDTH, V_WIDTH),
  localparam int unsigned SX_W     = sx_width(H_WIDTH, V_WIDTH),
  localparam int unsigned SY_W     = sy_width(H_WIDTH, V_WIDTH),
  localparam int unsigned D        = div_width(H_WIDTH, V_WIDTH),
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [H_WIDTH-1:0] x_in,
  input  logic [V_WIDTH-1:0] y_in,
  input  logic               valid_in,
  input  logic [NUM_CH-1:0]  mask_in,
  input  logic               tabulate_in,
  output logic               busy_out,
  output logic               overrun_out,
  output logic               valid_out,
  output logic [CH_W-1:0]    ch_out,
  output logic [H_WIDTH-1:0] x_out,
  output logic [V_WIDTH-1:0] y_out,
  output logic [CNT_W-1:0]   count_out,
  output logic               found_out,
  output logic               done_out
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CH_W-1:0]  LastCh = CH_W'(NUM_CH - 1);

  logic [SX_W-1:0]  sx_q [NUM_CH], sx_d [NUM_CH], sx_nxt [NUM_CH], snap_sx_q [NUM_CH], snap_sx_d [NUM_CH];
  logic [SY_W-1:0]  sy_q [NUM_CH], sy_d [NUM_CH], sy_nxt [NUM_CH], snap_sy_q [NUM_CH], snap_sy_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH], cnt_d [NUM_CH], cnt_nxt [NUM_CH];
  logic [CNT_W-1:0] snap_cnt_q [NUM_CH], snap_cnt_d [NUM_CH];
  logic [NUM_CH-1:0] sat_q, sat_d, sat_nxt, snap_sat_q, snap_sat_d;

  state_e state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d, ch_out_q, ch_out_d;
  logic [H_WIDTH-1:0] x_q, x_d;
  logic [V_WIDTH-1:0] y_q, y_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic valid_q, valid_d, done_q, done_d, found_q, found_d, ovr_q, ovr_d;

  logic [CNT_W-1:0] sel_cnt;
  logic             skip, div_start, done_x, done_y;
  logic [D:0]       rnd, x_sum, y_sum;
  logic [D-1:0]     quo_x, quo_y;

  // Accumulate every cycle; tabulate snapshots (when idle) and always clears the accumulators.
  always_comb begin
    snap_sat_d = snap_sat_q;
    sat_nxt    = sat_q;
    sat_d      = sat_q;
    for (int c = 0; c < NUM_CH; c++) begin
      sx_nxt[c]     = sx_q[c];
      sy_nxt[c]     = sy_q[c];
      cnt_nxt[c]    = cnt_q[c];
      snap_sx_d[c]  = snap_sx_q[c];
      snap_sy_d[c]  = snap_sy_q[c];
      snap_cnt_d[c] = snap_cnt_q[c];
      if (valid_in && mask_in[c] && !sat_q[c]) begin
        if (cnt_q[c] == CntMax) begin
          sat_nxt[c] = 1'b1;
        end else begin
          sx_nxt[c]  = sx_q[c] + SX_W'(x_in);
          sy_nxt[c]  = sy_q[c] + SY_W'(y_in);
          cnt_nxt[c] = cnt_q[c] + CNT_W'(1);
        end
      end
      sx_d[c]  = sx_nxt[c];
      sy_d[c]  = sy_nxt[c];
      cnt_d[c] = cnt_nxt[c];
      if (tabulate_in) begin
        if (state_q == StIdle) begin
          snap_sx_d[c]  = sx_nxt[c];
          snap_sy_d[c]  = sy_nxt[c];
          snap_cnt_d[c] = cnt_nxt[c];
          snap_sat_d[c] = sat_nxt[c];
        end
        sx_d[c]  = '0;
        sy_d[c]  = '0;
        cnt_d[c] = '0;
        sat_d[c] = 1'b0;
      end else begin
        sat_d[c] = sat_nxt[c];
      end
    end
  end

  // Dividend formation for the channel being processed, with optional half-divisor rounding.
  always_comb begin
    sel_cnt = snap_cnt_q[ch_q];
    skip    = (sel_cnt < CNT_W'(MIN_COUNT)) || snap_sat_q[ch_q];
    rnd     = '0;
    if (ROUND == RoundHalfUp) rnd = (D + 1)'(sel_cnt >> 1);
    x_sum = (D + 1)'(snap_sx_q[ch_q]) + rnd;
    y_sum = (D + 1)'(snap_sy_q[ch_q]) + rnd;
  end

  centroid_divider #(.DW(D), .VW(CNT_W)) u_div_x (
    .clk_i      (clk_in),
    .rst_ni     (rst_n_in),
    .start_i    (div_start),
    .dividend_i (x_sum[D-1:0]),
    .divisor_i  (sel_cnt),
    .quotient_o (quo_x),
    .done_o     (done_x)
  );

  centroid_divider #(.DW(D), .VW(CNT_W)) u_div_y (
    .clk_i      (clk_in),
    .rst_ni     (rst_n_in),
    .start_i    (div_start),
    .dividend_i (y_sum[D-1:0]),
    .divisor_i  (sel_cnt),
    .quotient_o (quo_y),
    .done_o     (done_y)
  );

  // Channel sequencer and registered result outputs.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    div_start = 1'b0;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    ovr_d     = tabulate_in && (state_q != StIdle);
    ch_out_d  = ch_out_q;
    x_d       = x_q;
    y_d       = y_q;
    count_d   = count_q;
    found_d   = found_q;
    unique case (state_q)
      StIdle: begin
        if (tabulate_in) begin
          state_d = StLoad;
          ch_d    = '0;
        end
      end
      StLoad: begin
        if (skip) begin
          state_d = StEmit;
        end else begin
          div_start = 1'b1;
          state_d   = StDiv;
        end
      end
      StDiv: begin
        if (done_x && done_y) state_d = StEmit;
      end
      StEmit: begin
        valid_d  = 1'b1;
        ch_out_d = ch_q;
        count_d  = sel_cnt;
        found_d  = !skip;
        x_d      = skip ? '0 : quo_x[H_WIDTH-1:0];
        y_d      = skip ? '0 : quo_y[V_WIDTH-1:0];
        done_d   = (ch_q == LastCh);
        if (ch_q == LastCh) begin
          state_d = StIdle;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, accumulator, snapshot and output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sx_q[c]       <= '0;
        sy_q[c]       <= '0;
        cnt_q[c]      <= '0;
        snap_sx_q[c]  <= '0;
        snap_sy_q[c]  <= '0;
        snap_cnt_q[c] <= '0;
      end
      sat_q      <= '0;
      snap_sat_q <= '0;
      state_q    <= StIdle;
      ch_q       <= '0;
      ch_out_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        sx_q[c]       <= sx_d[c];
        sy_q[c]       <= sy_d[c];
        cnt_q[c]      <= cnt_d[c];
        snap_sx_q[c]  <= snap_sx_d[c];
        snap_sy_q[c]  <= snap_sy_d[c];
        snap_cnt_q[c] <= snap_cnt_d[c];
      end
      sat_q      <= sat_d;
      snap_sat_q <= snap_sat_d;
      state_q    <= state_d;
      ch_q       <= ch_d;
      ch_out_q   <= ch_out_d;
      x_q        <= x_d;
      y_q        <= y_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      found_q    <= found_d;
      ovr_q      <= ovr_d;
    end
  end

  // Busy stays up through the done pulse so it falls one cycle later.
  assign busy_out    = (state_q != StIdle) || done_q;
  assign overrun_out = ovr_q;
  assign valid_out   = valid_q;
  assign ch_out      = ch_out_q;
  assign x_out       = x_q;
  assign y_out       = y_q;
  assign count_out   = count_q;
  assign found_out   = found_q;
  assign done_out    = done_q;

endmodule

// File: tb/tb_multi_centroid.sv
// Bench: two instances (truncating and rounding) driven identically, checked against a sum model.
module tb_multi_centroid;

  localparam int unsigned NCH  = 2;
  localparam int unsigned HW   = 11;
  localparam int unsigned VW   = 10;
  localparam int unsigned CW   = HW + VW;
  localparam int unsigned DW   = 32;
  localparam int unsigned MINC = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [HW-1:0] x_in = '0;
  logic [VW-1:0] y_in = '0;
  logic valid_in = 1'b0;
  logic [NCH-1:0] mask_in = '0;
  logic tabulate_in = 1'b0;

  logic busy [2], ovr [2], vld [2], found [2], done [2];
  logic [0:0]    chv [2];
  logic [HW-1:0] xo [2];
  logic [VW-1:0] yo [2];
  logic [CW-1:0] co [2];

  int vectors = 0;
  int errors  = 0;

  longint unsigned msx [NCH], msy [NCH], mcnt [NCH];
  longint unsigned esx [NCH], esy [NCH], ecnt [NCH];

  always #5 clk = ~clk;

  multi_centroid #(.NUM_CH(NCH), .H_WIDTH(HW), .V_WIDTH(VW), .MIN_COUNT(MINC), .ROUND(0)) u_trunc (
    .clk_in (clk), .rst_n_in (rst_n), .x_in (x_in), .y_in (y_in), .valid_in (valid_in),
    .mask_in (mask_in), .tabulate_in (tabulate_in), .busy_out (busy[0]), .overrun_out (ovr[0]),
    .valid_out (vld[0]), .ch_out (chv[0]), .x_out (xo[0]), .y_out (yo[0]), .count_out (co[0]),
    .found_out (found[0]), .done_out (done[0])
  );

  multi_centroid #(.NUM_CH(NCH), .H_WIDTH(HW), .V_WIDTH(VW), .MIN_COUNT(MINC), .ROUND(1)) u_round (
    .clk_in (clk), .rst_n_in (rst_n), .x_in (x_in), .y_in (y_in), .valid_in (valid_in),
    .mask_in (mask_in), .tabulate_in (tabulate_in), .busy_out (busy[1]), .overrun_out (ovr[1]),
    .valid_out (vld[1]), .ch_out (chv[1]), .x_out (xo[1]), .y_out (yo[1]), .count_out (co[1]),
    .found_out (found[1]), .done_out (done[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_add(input int x, input int y, input logic [NCH-1:0] m);
    for (int c = 0; c < NCH; c++) begin
      if (m[c]) begin
        msx[c]  += longint'(x);
        msy[c]  += longint'(y);
        mcnt[c] += 1;
      end
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      msx[c]  = 0;
      msy[c]  = 0;
      mcnt[c] = 0;
    end
  endtask

  task automatic pix(input int x, input int y, input logic [NCH-1:0] m);
    x_in     = HW'(x);
    y_in     = VW'(y);
    mask_in  = m;
    valid_in = 1'b1;
    model_add(x, y, m);
    tick();
    valid_in = 1'b0;
    mask_in  = '0;
  endtask

  task automatic tab(input bit wp, input int x, input int y, input logic [NCH-1:0] m);
    tabulate_in = 1'b1;
    if (wp) begin
      x_in     = HW'(x);
      y_in     = VW'(y);
      mask_in  = m;
      valid_in = 1'b1;
      model_add(x, y, m);
    end
    for (int c = 0; c < NCH; c++) begin
      esx[c]  = msx[c];
      esy[c]  = msy[c];
      ecnt[c] = mcnt[c];
    end
    model_clear();
    tick();
    tabulate_in = 1'b0;
    valid_in    = 1'b0;
    mask_in     = '0;
    for (int d = 0; d < 2; d++) chk("busy_rise", busy[d], 1);
  endtask

  // Waits for each channel result; n0 is the cycles already spent since the first LOAD.
  task automatic expect_frame(input int n0);
    int n;
    longint unsigned qx, qy, r;
    bit ok;
    for (int c = 0; c < NCH; c++) begin
      n = (c == 0) ? n0 : 0;
      do begin
        tick();
        n++;
      end while (vld[0] !== 1'b1 && n < 200);
      ok = (ecnt[c] >= MINC);
      chk("latency", n, ok ? DW + 2 : 2);
      if (n >= 200) return;
      for (int d = 0; d < 2; d++) begin
        r  = (d == 1) ? ecnt[c] / 2 : 0;
        qx = ok ? (esx[c] + r) / ecnt[c] : 0;
        qy = ok ? (esy[c] + r) / ecnt[c] : 0;
        chk("valid", vld[d], 1);
        chk("ch", chv[d], c);
        chk("x", xo[d], qx);
        chk("y", yo[d], qy);
        chk("count", co[d], ecnt[c]);
        chk("found", found[d], ok);
        chk("done", done[d], c == NCH - 1);
      end
    end
    for (int d = 0; d < 2; d++) chk("busy_at_done", busy[d], 1);
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("busy_fall", busy[d], 0);
      chk("valid_gap", vld[d], 0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int d = 0; d < 2; d++)
      chk(tag, {busy[d], ovr[d], vld[d], chv[d], xo[d], yo[d], co[d], found[d], done[d]}, 0);
  endtask

  initial begin
    int nv;
    int np;
    model_clear();
    #12;
    chk_all_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic centroid, empty second channel.
    pix(10, 20, 2'b01);
    pix(20, 40, 2'b01);
    tab(0, 0, 0, 2'b00);
    expect_frame(0);

    // Rounding: x = 1,2 gives 1 truncated, 2 rounded.
    pix(1, 0, 2'b01);
    pix(2, 0, 2'b01);
    tab(0, 0, 0, 2'b00);
    expect_frame(0);

    // Same-cycle pixel is part of the snapshot.
    tab(1, 100, 50, 2'b01);
    expect_frame(0);

    // Shared pixel in both channels.
    pix(7, 3, 2'b11);
    tab(0, 0, 0, 2'b00);
    expect_frame(0);

    // Overrun: second tabulate 5 cycles into the divide discards the in-progress frame.
    pix(300, 200, 2'b11);
    pix(40, 60, 2'b10);
    tab(0, 0, 0, 2'b00);
    pix(500, 500, 2'b11);
    pix(600, 100, 2'b01);
    pix(1, 1, 2'b10);
    tick();
    tick();
    tabulate_in = 1'b1;
    tick();
    tabulate_in = 1'b0;
    model_clear();
    for (int d = 0; d < 2; d++) chk("overrun", ovr[d], 1);
    expect_frame(6);
    pix(5, 9, 2'b01);
    tab(0, 0, 0, 2'b00);
    expect_frame(0);

    // Reset in the middle of a divide.
    pix(123, 321, 2'b11);
    tab(0, 0, 0, 2'b00);
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset_outputs");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (vld[0] === 1'b1 || vld[1] === 1'b1) nv++;
    end
    chk("no_valid_after_reset", nv, 0);
    pix(8, 8, 2'b10);
    pix(11, 13, 2'b10);
    tab(0, 0, 0, 2'b00);
    expect_frame(0);

    // Random frames.
    for (int f = 0; f < 5; f++) begin
      np = $urandom_range(0, 12);
      for (int i = 0; i < np; i++)
        pix($urandom_range(0, 2047), $urandom_range(0, 1023), NCH'($urandom_range(0, 3)));
      tab($urandom_range(0, 1), $urandom_range(0, 2047), $urandom_range(0, 1023),
          NCH'($urandom_range(0, 3)));
      expect_frame(0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/multi_centroid.md
Name: multi_centroid

Overview:
- Multi-channel, parametrised successor to the single-mask centre-of-mass block.
- Accumulates sum_x, sum_y and pixel count for NUM_CH independent pixel masks, e.g. per-colour or per-player masks from the camera pipeline.
- On tabulate, snapshots all channels and clears the accumulators, so the next frame accumulates while the snapshot is divided.
- Reports one centroid per channel, in channel order, with configurable rounding and a minimum-count qualifier.

Parameters:
- NUM_CH, 4: number of mask channels (1..16).
- H_WIDTH, 11: x coordinate width.
- V_WIDTH, 10: y coordinate width.
- MIN_COUNT, 1: a channel with count < MIN_COUNT reports found_out=0.
- ROUND, 0: 0 = truncating divide; 1 = round-half-up (count>>1 is added to the dividend).

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- x_in  input  H_WIDTH  pixel x.
- y_in  input  V_WIDTH  pixel y.
- valid_in  input  1  pixel qualifier.
- mask_in  input  NUM_CH  per-channel membership of the current pixel.
- tabulate_in  input  1  end-of-frame strobe.
- busy_out  output  1  snapshot is being divided.
- overrun_out  output  1  1-cycle pulse: tabulate arrived while busy.
- valid_out  output  1  1-cycle pulse per channel result.
- ch_out  output  $clog2(NUM_CH) (min 1)  channel index of the current result.
- x_out  output  H_WIDTH  centroid x.
- y_out  output  V_WIDTH  centroid y.
- count_out  output  CNT_W  channel pixel count.
- found_out  output  1  count >= MIN_COUNT and not saturated.
- done_out  output  1  pulses together with the last channel's valid_out.

Behaviour:
- Widths:
  - CNT_W = H_WIDTH+V_WIDTH.
  - SX_W = CNT_W+H_WIDTH.
  - SY_W = CNT_W+V_WIDTH.
  - D = max(SX_W, SY_W).
- Reset (rst_n_in low, asynchronous):
  - All outputs 0.
  - Accumulators, snapshot registers and count-saturation flags cleared.
  - FSM in IDLE.
  - Reset mid-divide abandons the frame; no valid_out or done_out follows.
- Accumulation runs every cycle regardless of FSM state:
  - If valid_in and mask_in[c]: sum_x[c] += x_in, sum_y[c] += y_in, count[c] += 1.
  - count saturates at 2^CNT_W-1 and sets a sticky sat[c]; sums freeze once sat[c] is set.
- tabulate_in while IDLE:
  - Snapshot all sums, counts and sat flags, then clear the accumulators.
  - A pixel presented in the same cycle as tabulate_in is included in the snapshot.
  - busy_out rises the next cycle.
- tabulate_in while busy:
  - Accumulators cleared (frame discarded); snapshot untouched.
  - overrun_out=1 for one cycle.
- FSM states: IDLE -> LOAD -> DIV -> EMIT -> (LOAD next channel | IDLE).
- LOAD(c):
  - If count < MIN_COUNT or sat[c]: go directly to EMIT with x_out=0, y_out=0, found_out=0, skipping the divide.
  - Otherwise start the x and y dividers together; the y dividend is zero-extended to D.
  - With ROUND=1, count>>1 is added to both dividends (D+1-bit add, no overflow possible for legal widths).
- DIV: exactly D cycles, one quotient bit per cycle. Both dividers finish on the same cycle.
- EMIT:
  - valid_out=1; ch_out=c; count_out=count[c].
  - x_out and y_out take the low H_WIDTH/V_WIDTH bits of the quotients; the quotient is <= max coordinate, so no truncation error.
  - found_out=1.
  - done_out=1 when c = NUM_CH-1.
- Timing:
  - Divided channel: LOAD to valid_out = D+2 cycles.
  - Skipped channel: 2 cycles.
  - busy_out falls the cycle after done_out.
  - valid_out never pulses on consecutive cycles.
- Outputs x_out, y_out, ch_out, count_out and found_out hold their values until the next EMIT.

Decomposition:
- centroid_pkg holds:
  - width functions CNT_W, SX_W, SY_W, D as localparam-computing functions;
  - state enum {IDLE, LOAD, DIV, EMIT};
  - rounding-mode constants.
- One sub-module: centroid_divider.
  - D-bit restoring serial divider.
  - Interface: start, dividend, divisor; produces quotient plus a done pulse after D cycles.
  - Instantiated twice (x, y).

Test Plan:
- NUM_CH=2, H=11, V=10, so D=32:
  - ch0 pixels (10,20) and (20,40); ch1 empty; tabulate.
  - Required: ch0 x=15, y=30, count=2, found=1, 34 cycles after LOAD.
  - Required: ch1 x=0, y=0, found=0, done_out=1.
- ROUND=1: ch0 pixels x=1,2 (y=0,0).
  - Required: x_out=2.
  - ROUND=0 gives 1.
- tabulate_in with a same-cycle pixel (100,50) as the only ch0 pixel.
  - Required: ch0 reports (100,50), count=1.
- Second tabulate 5 cycles into DIV.
  - Required: overrun_out pulse; current results unaffected.
  - Pixels accumulated before the second tabulate are discarded; the next frame starts clean.
- Pixel with mask_in=2'b11 at (7,3) in both channels.
  - Required: both channels report (7,3).
- rst_n_in asserted mid-DIV.
  - Required: all outputs 0 immediately.
  - Required: no valid_out afterwards; a new frame after reset completes normally.
